// File: rtl/accumulator_multi.sv
// Multi-channel load/transfer accumulator: one shared operand register feeding
// CHANNELS independent accumulators with optional signed arithmetic and saturation.
module accumulator_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             transfer,
    input  logic [1:0]       op,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             overflow,
    output logic             done
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_REP = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam bit IS_SAT    = (SATURATE != 0);

    localparam logic [WIDTH-1:0] MAX_VAL = IS_SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL = IS_SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0]    operand;
    logic [WIDTH-1:0]    acc [CHANNELS];
    logic [CHANNELS-1:0] ovf;

    logic             ch_ok;
    logic [WIDTH-1:0] cur_acc;
    logic             cur_ovf;

    // Channel decode by comparison so a ch_sel beyond CHANNELS never indexes the array.
    always_comb begin
        ch_ok   = 1'b0;
        cur_acc = '0;
        cur_ovf = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == CH_W'(i)) begin
                ch_ok   = 1'b1;
                cur_acc = acc[i];
                cur_ovf = ovf[i];
            end
        end
    end

    assign data_out = cur_acc;
    assign overflow = cur_ovf;

    logic [WIDTH:0]   ext_acc;
    logic [WIDTH:0]   ext_opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] add_sat;
    logic [WIDTH-1:0] sub_sat;
    logic [WIDTH-1:0] next_acc;
    logic             next_ovf;

    always_comb begin
        ext_acc  = IS_SIGNED ? {cur_acc[WIDTH-1], cur_acc} : {1'b0, cur_acc};
        ext_opnd = IS_SIGNED ? {operand[WIDTH-1], operand} : {1'b0, operand};
        sum      = ext_acc + ext_opnd;
        diff     = ext_acc - ext_opnd;
        if (IS_SIGNED) begin
            add_ovf = (cur_acc[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != cur_acc[WIDTH-1]);
            sub_ovf = (cur_acc[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] != cur_acc[WIDTH-1]);
        end else begin
            add_ovf = sum[WIDTH];
            sub_ovf = diff[WIDTH];
        end
        // Signed overflow always leaves acc's sign behind, so acc's sign picks the clamp rail.
        add_sat = (IS_SIGNED && cur_acc[WIDTH-1])  ? MIN_VAL : MAX_VAL;
        sub_sat = (IS_SIGNED && !cur_acc[WIDTH-1]) ? MAX_VAL : MIN_VAL;
    end

    always_comb begin
        next_acc = cur_acc;
        next_ovf = cur_ovf;
        case (op)
            OP_ADD: begin
                next_acc = (add_ovf && IS_SAT) ? add_sat : sum[WIDTH-1:0];
                next_ovf = cur_ovf | add_ovf;
            end
            OP_SUB: begin
                next_acc = (sub_ovf && IS_SAT) ? sub_sat : diff[WIDTH-1:0];
                next_ovf = cur_ovf | sub_ovf;
            end
            OP_REP: begin
                next_acc = operand;
            end
            OP_CLR: begin
                next_acc = '0;
                next_ovf = 1'b0;
            end
            default: begin
                next_acc = cur_acc;
            end
        endcase
    end

    // transfer is accepted on any edge where ch_sel names a real channel; done is the
    // one-cycle acknowledgement of that acceptance and has no back-pressure.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            operand <= '0;
            ovf     <= '0;
            done    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            done <= transfer && ch_ok;
            if (transfer) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (ch_ok && (ch_sel == CH_W'(i))) begin
                        acc[i] <= next_acc;
                        ovf[i] <= next_ovf;
                    end
                end
            end else if (load) begin
                operand <= data_in;
            end
        end
    end

endmodule

// File: doc/accumulator_multi.md
Name: accumulator_multi

Overview:
Parametrised, multi-channel successor to the single 16-bit load/transfer accumulator.
- Holds CHANNELS independent accumulators, each WIDTH bits wide.
- A shared operand register is filled by load and applied to the selected channel on transfer.
- Supports add, subtract, replace and clear-channel operations; signed or unsigned arithmetic; optional saturation; sticky per-channel overflow flags.
- Sits in the datapath wherever running sums are needed, e.g. per-channel totals and counters.

Parameters:
WIDTH, 16, data width of the operand register, each accumulator and data_out
CHANNELS, 4, number of accumulators (1..16)
CH_W, 2, width of ch_sel; must satisfy 2**CH_W >= CHANNELS
SIGNED, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic
SATURATE, 0, 0 = wrap on overflow, 1 = clamp to the representable limit

Ports:
clock  input  1  single system clock, rising edge
clear  input  1  asynchronous active-low reset
load  input  1  capture data_in into the operand register
transfer  input  1  apply op to acc[ch_sel] using the operand register
op  input  2  00 add, 01 subtract, 10 replace, 11 clear channel
ch_sel  input  CH_W  channel index for transfer and for the read outputs
data_in  input  WIDTH  operand data
data_out  output  WIDTH  acc[ch_sel], combinational read
overflow  output  1  sticky overflow flag of channel ch_sel, combinational read
done  output  1  registered one-cycle pulse following each accepted transfer

Behaviour:
- Reset: one clock, clock; clear is asynchronous and active-low.
  - clear=0 forces operand register=0, every acc=0, every ovf flag=0, done=0, independent of clock.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation aborts any pending update; no partial write survives.
- Priority per edge: transfer over load.
  - transfer=1 and load=1 in the same cycle: operand register is not updated; the transfer uses the old operand.
- Load: load=1, transfer=0 -> operand <= data_in at the edge. Usable by a transfer from the next cycle.
- Transfer: at the edge, acc[ch_sel] updates; the other channels are untouched.
  - op=00: acc + operand.
  - op=01: acc - operand.
  - op=10: acc <= operand; ovf[ch] unchanged.
  - op=11: acc <= 0 and ovf[ch] <= 0.
- Arithmetic is computed at WIDTH+1 bits.
  - Unsigned: overflow = carry out on add, borrow on sub.
  - Signed: overflow = operand signs agree (add) or differ (sub), and the result sign differs from acc's sign.
- On overflow:
  - SATURATE=0: keep the low WIDTH bits (wrap).
  - SATURATE=1, unsigned: add clamps to all-ones; sub clamps to 0.
  - SATURATE=1, signed: clamp to the max positive or min negative value, by direction.
  - In all cases ovf[ch] <= 1 (sticky). Only op=11 or reset clears it.
- Out-of-range channel: ch_sel >= CHANNELS -> transfer ignored, done stays 0, data_out=0, overflow=0.
- Latency:
  - data_out and overflow are combinational from the state and ch_sel, so the updated value is visible immediately after the transfer edge.
  - done=1 for exactly one cycle after each accepted transfer.
  - Back-to-back transfers give a continuous done high.
- Idle: load=0, transfer=0 -> all state holds.

Test Plan:
- Reset and accumulate (defaults): clear=0 mid-run -> data_out=0, overflow=0, done=0 asynchronously. Then load 0x0005, transfer op=00 ch=0 three times -> data_out=0x000F, done high 3 cycles.
- Channel isolation: load 0x0100; transfer add ch=1, then ch=2 twice -> ch1=0x0100, ch2=0x0200, ch0 and ch3 = 0.
- Wrap versus saturate, unsigned: ch0=0xFFF0, operand 0x0020, add.
  - SATURATE=0 -> 0x0010, overflow=1.
  - SATURATE=1 -> 0xFFFF, overflow=1.
  - Then op=11 -> 0x0000, overflow=0.
- Signed saturation (SIGNED=1, SATURATE=1): acc=0x7FF0, add 0x0100 -> 0x7FFF, overflow=1. acc=0x8010, sub 0x0100 -> 0x8000.
- Simultaneous load and transfer: operand=0x0003, then load=1 data_in=0x0100 with transfer add ch0 from 0 -> acc=0x0003. Next transfer -> 0x0006 (operand still 0x0003).
- Out of range (CHANNELS=3, ch_sel=3): transfer -> no channel changes, done=0, data_out=0.
